priv_trap_sequencer: RTL and testbench
======================================

PRIV_TRAP_SEQUENCER -- requirements
Module: priv_trap_sequencer

Interface
REQ-001 SHALL have ports, clock and reset first:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- exc_req  in  9  exception sources: [0] mal_insn, [1] fault_insn, [2] illegal_insn, [3] breakpoint, [4] mal_l, [5] fault_l, [6] mal_s, [7] fault_s, [8] env_m
- timer_int, soft_int, ext_int  in  1 each  interrupt pending
- mie_t, mie_s, mie_e  in  1 each  interrupt enables
- mstatus_ie, mstatus_ie1  in  1 each  current interrupt-enable stack
- ret  in  1  mret request
- epc, badaddr  in  32 each  faulting PC and address
- mtvec, mepc  in  32 each  trap vector and saved PC
- pipe_drained  in  1  pipeline flush complete
- pipe_clear  out  1  flush request
- mcause_rup, mepc_rup, mbadaddr_rup, mstatus_rup  out  1 each  CSR write strobes
- mcause_next, mepc_next, mbadaddr_next  out  32 each  CSR write data
- mstatus_ie_next, mstatus_ie1_next  out  1 each  stacked enables
- insert_pc  out  1  PC redirect strobe
- priv_pc  out  32  redirect target
- busy  out  1  FSM not IDLE

Function
REQ-002 SHALL implement FSM states IDLE, DRAIN, COMMIT, REDIRECT; busy = (state != IDLE).
REQ-003 Interrupt eligible iff mstatus_ie && pending && matching enable.
REQ-004 In IDLE, if any exc_req bit set, SHALL select highest priority in order mal_insn, fault_insn, illegal_insn, breakpoint, mal_l, fault_l, mal_s, fault_s, env_m; causes 0,1,2,3,4,5,6,7,11; interrupt flag 0.
REQ-005 Else if an interrupt is eligible, SHALL select ext (11) > soft (3) > timer (7), mcause[31]=1.
REQ-006 Else if ret, SHALL start a return sequence.
REQ-007 Trap beats ret on the same cycle; exceptions beat interrupts.
REQ-008 On leaving IDLE, SHALL latch cause, kind (trap/ret), epc and badaddr into registers; next state DRAIN.
REQ-009 DRAIN: pipe_clear=1 each cycle; go to COMMIT the cycle after pipe_drained=1; all new requests ignored.
REQ-010 COMMIT, trap: single cycle asserting all four rup strobes; mcause_next=latched cause, mepc_next=latched epc, mbadaddr_next=latched badaddr, mstatus_ie1_next=mstatus_ie, mstatus_ie_next=0.
REQ-011 COMMIT, ret: only mstatus_rup=1; mstatus_ie_next=mstatus_ie1, mstatus_ie1_next=1.
REQ-012 REDIRECT: single cycle insert_pc=1; priv_pc=mtvec for trap, mepc for ret; then IDLE.
REQ-013 Minimum trap latency request-to-insert_pc: 3 cycles when pipe_drained is already high.
REQ-014 Outside their states, strobes, pipe_clear and insert_pc SHALL be 0; data outputs SHALL hold latched values.

Reset
REQ-015 RST SHALL force IDLE, clear all latches, drive every output 0. Applies mid-sequence, with no partial CSR write in the following cycle.
REQ-016 Requests present in the reset-release cycle SHALL be sampled on the next clock edge.

Configuration
REQ-017 With RMGMT_EXC_EN defined, SHALL add inputs ex_rmgmt (1) and ex_rmgmt_cause (2), lowest exception priority (above interrupts), cause = 24 + ex_rmgmt_cause.
REQ-018 Without RMGMT_EXC_EN, those ports and that logic SHALL be absent.

Verification
REQ-019 exc_req=9'h024 (illegal+fault_l), epc=0x100, pipe_drained=1 -> mcause_next=2, mepc_next=0x100, insert_pc with priv_pc=mtvec 3 cycles after request.
REQ-020 ext_int+timer_int, mie_e=mie_t=1, mstatus_ie=1 -> mcause_next=0x8000000B, mstatus_ie_next=0, mstatus_ie1_next=1.
REQ-021 Same interrupt with mstatus_ie=0 -> FSM stays IDLE, busy=0.
REQ-022 ret plus exc_req[8] on the same cycle -> trap sequence with cause 11, no ret.
REQ-023 pipe_drained held 0 for 5 cycles -> pipe_clear high 5+ cycles, COMMIT one cycle after drained rises; RST asserted in DRAIN -> all outputs 0 and no rup pulse.
REQ-024 With RMGMT_EXC_EN: ex_rmgmt=1, cause=2, no other requests -> mcause_next=26.

Source files
------------

// File: rtl/priv_trap_sequencer.sv
// Trap / mret sequencer: drain the pipe, commit CSRs, redirect the PC.
// Optional macro RMGMT_EXC_EN adds the resource-management exception.
module priv_trap_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic [8:0]  exc_req,
`ifdef RMGMT_EXC_EN
  input  logic        ex_rmgmt,
  input  logic [1:0]  ex_rmgmt_cause,
`endif
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        ext_int,
  input  logic        mie_t,
  input  logic        mie_s,
  input  logic        mie_e,
  input  logic        mstatus_ie,
  input  logic        mstatus_ie1,
  input  logic        ret,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        pipe_drained,
  output logic        pipe_clear,
  output logic        mcause_rup,
  output logic        mepc_rup,
  output logic        mbadaddr_rup,
  output logic        mstatus_rup,
  output logic [31:0] mcause_next,
  output logic [31:0] mepc_next,
  output logic [31:0] mbadaddr_next,
  output logic        mstatus_ie_next,
  output logic        mstatus_ie1_next,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE, DRAIN, COMMIT, REDIRECT
  } state_e;

  state_e      state_q, state_d;
  logic        trap_q;
  logic [31:0] cause_q, epc_q, bad_q, pc_q;
  logic        ie_q, ie1_q;

  logic        exc_any, int_e, int_s, int_t;
  logic        take_trap, take_ret;
  logic [31:0] cause_sel;

`ifdef RMGMT_EXC_EN
  assign exc_any = (|exc_req) | ex_rmgmt;
`else
  assign exc_any = |exc_req;
`endif

  assign int_e = mstatus_ie & ext_int & mie_e;
  assign int_s = mstatus_ie & soft_int & mie_s;
  assign int_t = mstatus_ie & timer_int & mie_t;

  // Pick the winning request: exceptions, then interrupts, then mret
  always_comb begin
    take_trap = 1'b0;
    take_ret  = 1'b0;
    cause_sel = '0;
    if (exc_any) begin
      take_trap = 1'b1;
      priority case (1'b1)
        exc_req[0]: cause_sel = 32'd0;
        exc_req[1]: cause_sel = 32'd1;
        exc_req[2]: cause_sel = 32'd2;
        exc_req[3]: cause_sel = 32'd3;
        exc_req[4]: cause_sel = 32'd4;
        exc_req[5]: cause_sel = 32'd5;
        exc_req[6]: cause_sel = 32'd6;
        exc_req[7]: cause_sel = 32'd7;
        exc_req[8]: cause_sel = 32'd11;
        default: begin
`ifdef RMGMT_EXC_EN
          cause_sel = 32'd24 + {30'd0, ex_rmgmt_cause};
`else
          cause_sel = 32'd0;
`endif
        end
      endcase
    end else if (int_e) begin
      take_trap = 1'b1;
      cause_sel = 32'h8000_000B;
    end else if (int_s) begin
      take_trap = 1'b1;
      cause_sel = 32'h8000_0003;
    end else if (int_t) begin
      take_trap = 1'b1;
      cause_sel = 32'h8000_0007;
    end else if (ret) begin
      take_ret = 1'b1;
    end
  end

  // Next state and outputs; reset blanks everything at once
  always_comb begin
    state_d          = state_q;
    pipe_clear       = 1'b0;
    mcause_rup       = 1'b0;
    mepc_rup         = 1'b0;
    mbadaddr_rup     = 1'b0;
    mstatus_rup      = 1'b0;
    mstatus_ie_next  = ie_q;
    mstatus_ie1_next = ie1_q;
    insert_pc        = 1'b0;
    priv_pc          = pc_q;
    mcause_next      = cause_q;
    mepc_next        = epc_q;
    mbadaddr_next    = bad_q;
    busy             = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (take_trap || take_ret) state_d = DRAIN;
      end
      DRAIN: begin
        pipe_clear = 1'b1;
        if (pipe_drained) state_d = COMMIT;
      end
      COMMIT: begin
        state_d     = REDIRECT;
        mstatus_rup = 1'b1;
        if (trap_q) begin
          mcause_rup       = 1'b1;
          mepc_rup         = 1'b1;
          mbadaddr_rup     = 1'b1;
          mstatus_ie_next  = 1'b0;
          mstatus_ie1_next = mstatus_ie;
        end else begin
          mstatus_ie_next  = mstatus_ie1;
          mstatus_ie1_next = 1'b1;
        end
      end
      REDIRECT: begin
        state_d   = IDLE;
        insert_pc = 1'b1;
        priv_pc   = trap_q ? mtvec : mepc;
      end
      default: state_d = IDLE;
    endcase
    if (RST) begin
      state_d          = IDLE;
      pipe_clear       = 1'b0;
      mcause_rup       = 1'b0;
      mepc_rup         = 1'b0;
      mbadaddr_rup     = 1'b0;
      mstatus_rup      = 1'b0;
      mstatus_ie_next  = 1'b0;
      mstatus_ie1_next = 1'b0;
      insert_pc        = 1'b0;
      priv_pc          = '0;
      mcause_next      = '0;
      mepc_next        = '0;
      mbadaddr_next    = '0;
      busy             = 1'b0;
    end
  end

  // State register plus latched request and held output values
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      trap_q  <= 1'b0;
      cause_q <= '0;
      epc_q   <= '0;
      bad_q   <= '0;
      pc_q    <= '0;
      ie_q    <= 1'b0;
      ie1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ie_q    <= mstatus_ie_next;
      ie1_q   <= mstatus_ie1_next;
      pc_q    <= priv_pc;
      if (state_q == IDLE && state_d == DRAIN) begin
        trap_q  <= take_trap;
        cause_q <= cause_sel;
        epc_q   <= epc;
        bad_q   <= badaddr;
      end
    end
  end

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// Bench for priv_trap_sequencer: directed scenarios plus random
// requests checked against a transaction-level reference model.
module tb_priv_trap_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [8:0]  exc_req = '0;
`ifdef RMGMT_EXC_EN
  logic        ex_rmgmt = 1'b0;
  logic [1:0]  ex_rmgmt_cause = '0;
`endif
  logic        timer_int = 0, soft_int = 0, ext_int = 0;
  logic        mie_t = 0, mie_s = 0, mie_e = 0;
  logic        mstatus_ie = 0, mstatus_ie1 = 0, ret = 0;
  logic [31:0] epc = '0, badaddr = '0, mtvec = '0, mepc = '0;
  logic        pipe_drained = 1'b0;
  logic        pipe_clear, mcause_rup, mepc_rup;
  logic        mbadaddr_rup, mstatus_rup;
  logic [31:0] mcause_next, mepc_next, mbadaddr_next;
  logic        mstatus_ie_next, mstatus_ie1_next, insert_pc;
  logic [31:0] priv_pc;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_cause, m_epc, m_bad, m_pc;
  logic        m_ie, m_ie1;

  priv_trap_sequencer dut (
    .CLK(CLK), .RST(RST), .exc_req(exc_req),
`ifdef RMGMT_EXC_EN
    .ex_rmgmt(ex_rmgmt), .ex_rmgmt_cause(ex_rmgmt_cause),
`endif
    .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
    .mie_t(mie_t), .mie_s(mie_s), .mie_e(mie_e),
    .mstatus_ie(mstatus_ie), .mstatus_ie1(mstatus_ie1), .ret(ret),
    .epc(epc), .badaddr(badaddr), .mtvec(mtvec), .mepc(mepc),
    .pipe_drained(pipe_drained), .pipe_clear(pipe_clear),
    .mcause_rup(mcause_rup), .mepc_rup(mepc_rup),
    .mbadaddr_rup(mbadaddr_rup), .mstatus_rup(mstatus_rup),
    .mcause_next(mcause_next), .mepc_next(mepc_next),
    .mbadaddr_next(mbadaddr_next),
    .mstatus_ie_next(mstatus_ie_next),
    .mstatus_ie1_next(mstatus_ie1_next),
    .insert_pc(insert_pc), .priv_pc(priv_pc), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [136:0] outs_vec();
    return {pipe_clear, mcause_rup, mepc_rup, mbadaddr_rup,
            mstatus_rup, mcause_next, mepc_next, mbadaddr_next,
            mstatus_ie_next, mstatus_ie1_next, insert_pc,
            priv_pc, busy};
  endfunction

  function automatic logic [3:0] rups();
    return {mcause_rup, mepc_rup, mbadaddr_rup, mstatus_rup};
  endfunction

  // Reference: 0 = nothing, 1 = trap, 2 = mret
  function automatic void predict(output int kind,
                                  output logic [31:0] cause);
    int codes [9];
    codes = '{0, 1, 2, 3, 4, 5, 6, 7, 11};
    kind  = 0;
    cause = '0;
    for (int i = 0; i < 9; i++) begin
      if (exc_req[i]) begin
        kind  = 1;
        cause = 32'(codes[i]);
        return;
      end
    end
`ifdef RMGMT_EXC_EN
    if (ex_rmgmt) begin
      kind  = 1;
      cause = 32'd24 + 32'(ex_rmgmt_cause);
      return;
    end
`endif
    if (mstatus_ie) begin
      if (ext_int && mie_e) begin
        kind = 1; cause = 32'h8000_000B; return;
      end
      if (soft_int && mie_s) begin
        kind = 1; cause = 32'h8000_0003; return;
      end
      if (timer_int && mie_t) begin
        kind = 1; cause = 32'h8000_0007; return;
      end
    end
    if (ret) kind = 2;
  endfunction

  task automatic clear_reqs();
    exc_req   = '0;
    ret       = 1'b0;
    timer_int = 1'b0;
    soft_int  = 1'b0;
    ext_int   = 1'b0;
`ifdef RMGMT_EXC_EN
    ex_rmgmt  = 1'b0;
`endif
  endtask

  task automatic model_reset();
    m_cause = '0; m_epc = '0; m_bad = '0; m_pc = '0;
    m_ie = 1'b0; m_ie1 = 1'b0;
  endtask

  // Requests are already on the inputs (set at a negedge) on entry
  task automatic run_seq(input int d, input bit inject);
    int          kind, cyc;
    logic [31:0] cause, l_epc, l_bad, pc_exp;
    logic [3:0]  rexp;
    logic        ie_exp, ie1_exp;
    predict(kind, cause);
    l_epc = epc;
    l_bad = badaddr;
    @(negedge CLK);
    clear_reqs();
    if (kind == 0) begin
      n_tests++;
      if ({busy, pipe_clear} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_no_req: busy/clear %b want 00",
                 {busy, pipe_clear});
      end
      return;
    end
    m_cause = cause; m_epc = l_epc; m_bad = l_bad;
    cyc = 1;
    for (int k = 1; k <= d + 1; k++) begin
      n_tests++;
      if ({busy, pipe_clear, insert_pc} !== 3'b110) begin
        n_fail++;
        $display("FAIL drain_sig: busy/clear/ins %b want 110",
                 {busy, pipe_clear, insert_pc});
      end
      n_tests++;
      if (rups() !== 4'b0000) begin
        n_fail++;
        $display("FAIL drain_rup: got %b want 0000", rups());
      end
      n_tests++;
      if (mcause_next !== m_cause) begin
        n_fail++;
        $display("FAIL drain_cause: got %h want %h",
                 mcause_next, m_cause);
      end
      pipe_drained = (k >= d + 1);
      if (inject) begin
        exc_req = 9'($urandom);
        ret     = 1'($urandom);
        ext_int = 1'b1;
      end
      @(negedge CLK);
      cyc++;
    end
    clear_reqs();
    rexp    = (kind == 1) ? 4'b1111 : 4'b0001;
    ie_exp  = (kind == 1) ? 1'b0 : mstatus_ie1;
    ie1_exp = (kind == 1) ? mstatus_ie : 1'b1;
    n_tests++;
    if (rups() !== rexp) begin
      n_fail++;
      $display("FAIL commit_rup: got %b want %b", rups(), rexp);
    end
    n_tests++;
    if ({mstatus_ie_next, mstatus_ie1_next} !== {ie_exp, ie1_exp}) begin
      n_fail++;
      $display("FAIL commit_ie: got %b want %b",
               {mstatus_ie_next, mstatus_ie1_next}, {ie_exp, ie1_exp});
    end
    n_tests++;
    if ({mcause_next, mepc_next, mbadaddr_next} !==
        {m_cause, m_epc, m_bad}) begin
      n_fail++;
      $display("FAIL commit_data: got %h %h %h want %h %h %h",
               mcause_next, mepc_next, mbadaddr_next,
               m_cause, m_epc, m_bad);
    end
    n_tests++;
    if ({pipe_clear, insert_pc, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL commit_sig: got %b want 001",
               {pipe_clear, insert_pc, busy});
    end
    m_ie = ie_exp; m_ie1 = ie1_exp;
    @(negedge CLK);
    cyc++;
    pc_exp = (kind == 1) ? mtvec : mepc;
    n_tests++;
    if ({insert_pc, busy, rups()} !== 6'b110000) begin
      n_fail++;
      $display("FAIL redir_sig: got %b want 110000",
               {insert_pc, busy, rups()});
    end
    n_tests++;
    if (priv_pc !== pc_exp) begin
      n_fail++;
      $display("FAIL redir_pc: got %h want %h", priv_pc, pc_exp);
    end
    if (d == 0) begin
      n_tests++;
      if (cyc !== 3) begin
        n_fail++;
        $display("FAIL latency: got %0d want 3", cyc);
      end
    end
    m_pc = pc_exp;
    @(negedge CLK);
    n_tests++;
    if ({busy, insert_pc, pipe_clear, rups()} !== 7'b0) begin
      n_fail++;
      $display("FAIL back_idle: got %b want 0",
               {busy, insert_pc, pipe_clear, rups()});
    end
    n_tests++;
    if ({priv_pc, mstatus_ie_next, mstatus_ie1_next, mcause_next,
         mepc_next, mbadaddr_next} !==
        {m_pc, m_ie, m_ie1, m_cause, m_epc, m_bad}) begin
      n_fail++;
      $display("FAIL hold: pc %h ie %b%b cause %h want %h %b%b %h",
               priv_pc, mstatus_ie_next, mstatus_ie1_next,
               mcause_next, m_pc, m_ie, m_ie1, m_cause);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    exc_req = 9'h1FF;
    ret = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_tests++;
    if (outs_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0", outs_vec());
    end
    @(negedge CLK);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_reset_release();
    // RST drops together with a request; next edge must take it
    clear_reqs();
    exc_req = 9'h004;
    epc = 32'h40; badaddr = 32'h44;
    mtvec = 32'h0000_0200; mepc = 32'h0;
    pipe_drained = 1'b1;
    RST = 1'b0;
    run_seq(0, 1'b0);
  endtask

  task automatic test_exc_priority();
    exc_req = 9'h024;
    epc = 32'h100; badaddr = 32'hDEAD_0004;
    mtvec = 32'h8000_0100;
    mstatus_ie = 1'b1; mstatus_ie1 = 1'b0;
    pipe_drained = 1'b1;
    run_seq(0, 1'b0);
    n_tests++;
    if ({mcause_next, mepc_next} !== {32'd2, 32'h100}) begin
      n_fail++;
      $display("FAIL illegal_cause: got %h %h want 2 100",
               mcause_next, mepc_next);
    end
  endtask

  task automatic test_interrupt();
    ext_int = 1'b1; timer_int = 1'b1;
    mie_e = 1'b1; mie_t = 1'b1; mie_s = 1'b0;
    mstatus_ie = 1'b1; mstatus_ie1 = 1'b0;
    epc = 32'h2000; mtvec = 32'h0000_0400;
    pipe_drained = 1'b1;
    run_seq(0, 1'b0);
    n_tests++;
    if ({mcause_next, mstatus_ie_next, mstatus_ie1_next} !==
        {32'h8000_000B, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ext_int: got %h %b%b want 8000000b 01",
               mcause_next, mstatus_ie_next, mstatus_ie1_next);
    end
  endtask

  task automatic test_int_masked();
    ext_int = 1'b1; timer_int = 1'b1;
    mie_e = 1'b1; mie_t = 1'b1;
    mstatus_ie = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_tests++;
      if ({busy, pipe_clear} !== 2'b00) begin
        n_fail++;
        $display("FAIL int_masked: busy/clear %b want 00",
                 {busy, pipe_clear});
      end
    end
    clear_reqs();
  endtask

  task automatic test_trap_beats_ret();
    ret = 1'b1;
    exc_req = 9'h100;
    epc = 32'h3000; badaddr = 32'h0;
    mtvec = 32'h0000_0800; mepc = 32'h5555_0000;
    mstatus_ie = 1'b1; mstatus_ie1 = 1'b1;
    pipe_drained = 1'b1;
    run_seq(0, 1'b0);
    n_tests++;
    if (mcause_next !== 32'd11) begin
      n_fail++;
      $display("FAIL ecall_vs_ret: got %h want b", mcause_next);
    end
  endtask

  task automatic test_ret();
    ret = 1'b1;
    mepc = 32'h0000_1234;
    mstatus_ie = 1'b0; mstatus_ie1 = 1'b1;
    pipe_drained = 1'b0;
    run_seq(2, 1'b1);
  endtask

  task automatic test_long_drain();
    exc_req = 9'h008;
    epc = 32'h7000; mtvec = 32'h0000_0C00;
    pipe_drained = 1'b0;
    run_seq(5, 1'b1);
  endtask

  task automatic test_reset_mid();
    exc_req = 9'h002;
    epc = 32'h9000; badaddr = 32'h9004;
    pipe_drained = 1'b0;
    @(negedge CLK);
    clear_reqs();
    n_tests++;
    if ({busy, pipe_clear} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_enter: busy/clear %b want 11",
               {busy, pipe_clear});
    end
    pipe_drained = 1'b1;
    RST = 1'b1;
    #1;
    n_tests++;
    if (outs_vec() !== '0) begin
      n_fail++;
      $display("FAIL mid_rst_now: got %h want 0", outs_vec());
    end
    model_reset();
    @(negedge CLK);
    n_tests++;
    if (outs_vec() !== '0) begin
      n_fail++;
      $display("FAIL mid_rst_edge: got %h want 0", outs_vec());
    end
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_tests++;
      if (outs_vec() !== '0) begin
        n_fail++;
        $display("FAIL mid_rst_after: got %h want 0", outs_vec());
      end
    end
  endtask

`ifdef RMGMT_EXC_EN
  task automatic test_rmgmt();
    ex_rmgmt = 1'b1;
    ex_rmgmt_cause = 2'd2;
    mstatus_ie = 1'b1;
    ext_int = 1'b1; mie_e = 1'b1;
    pipe_drained = 1'b1;
    run_seq(0, 1'b0);
    n_tests++;
    if (mcause_next !== 32'd26) begin
      n_fail++;
      $display("FAIL rmgmt_cause: got %h want 1a", mcause_next);
    end
  endtask
`endif

  task automatic test_random();
    int d;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: exc_req = 9'($urandom);
        1: exc_req = 9'(1) << $urandom_range(0, 8);
        default: exc_req = '0;
      endcase
`ifdef RMGMT_EXC_EN
      ex_rmgmt = 1'($urandom);
      ex_rmgmt_cause = 2'($urandom);
`endif
      timer_int = 1'($urandom); soft_int = 1'($urandom);
      ext_int = 1'($urandom);
      mie_t = 1'($urandom); mie_s = 1'($urandom);
      mie_e = 1'($urandom);
      mstatus_ie = 1'($urandom); mstatus_ie1 = 1'($urandom);
      ret = 1'($urandom);
      epc = $urandom; badaddr = $urandom;
      mtvec = $urandom; mepc = $urandom;
      d = $urandom_range(0, 3);
      pipe_drained = (d == 0);
      run_seq(d, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_exc_priority();
    test_interrupt();
    test_int_masked();
    test_trap_beats_ret();
    test_ret();
    test_long_drain();
    test_reset_mid();
`ifdef RMGMT_EXC_EN
    test_rmgmt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
